pio_input_edge_irq: RTL and testbench

- Parametrised successor to the basic Avalon-MM input PIO.
- Per-bit features:
  - synchronises an asynchronous input bus (switches, keys) into clk;
  - debounces each bit;
  - detects configurable edges;
  - latches them in a write-1-to-clear edge-capture register;
  - drives a maskable level interrupt to the Nios II.
- Sits on the system interconnect as an Avalon-MM slave with fixed read latency 1.

---
 rtl/pio_input_edge_irq_if.sv | 11 +
 rtl/pio_input_edge_irq.sv | 64 ++++++
 tb/tb_pio_input_edge_irq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pio_input_edge_irq_if.sv
// pio_input_edge_irq_if: Avalon-MM slave bus (address, chipselect, write_n, writedata in; readdata, irq out)
interface pio_input_edge_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/pio_input_edge_irq.sv
// pio_input_edge_irq: synchronised, debounced input PIO with W1C edge capture and masked irq (clk, reset, in_port, bus: address/chipselect/write_n/writedata -> readdata/irq)
module pio_input_edge_irq #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    in_port,
  pio_input_edge_irq_if.slave bus
);
  localparam int CW = DEBOUNCE_CYCLES > 0 ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] synced, stable, stable_prev, irq_mask, edge_capture, ev, clr;
  logic [31:0] rd_next;
  logic wr, unused_wd;
  assign synced = sync_q[SYNC_STAGES-1];
  assign wr = bus.chipselect & ~bus.write_n;
  assign unused_wd = ^bus.writedata;
  always_ff @(posedge clk) sync_q <= reset ? '0 : {sync_q[SYNC_STAGES-2:0], in_port};
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk) stable <= reset ? '0 : synced;
    end else begin : g_deb
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] cnt;
        logic s;
        always_ff @(posedge clk)
          if (reset) begin
            cnt <= '0;
            s   <= 1'b0;
          end else if (synced[i] == s) cnt <= '0;
          else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt <= '0;
            s   <= synced[i];
          end else cnt <= cnt + 1'b1;
        assign stable[i] = s;
      end
    end
  endgenerate
  always_comb begin
    ev = EDGE_TYPE == 0 ? stable & ~stable_prev :
         EDGE_TYPE == 1 ? ~stable & stable_prev : stable ^ stable_prev;
    clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
    rd_next = bus.address == 2'd0 ? 32'(stable) :
              bus.address == 2'd2 ? 32'(irq_mask) :
              bus.address == 2'd3 ? 32'(edge_capture) : 32'd0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      stable_prev  <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      stable_prev  <= stable;
      if (wr && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clr) | ev;
      bus.irq      <= |(edge_capture & irq_mask);
      bus.readdata <= rd_next;
    end
endmodule

// File: tb/tb_pio_input_edge_irq.sv
// tb_pio_input_edge_irq: three PIO configurations against a window-based reference model
module tb_pio_input_edge_irq;
  localparam int WS [3] = '{8, 8, 32};
  localparam int SS [3] = '{2, 2, 3};
  localparam int DS [3] = '{4, 0, 0};
  localparam int ES [3] = '{2, 0, 1};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] address = '0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0] in0 = '0, in1 = '0;
  logic [31:0] in2 = '0;
  int tests = 0, fails = 0;
  logic [31:0] m_sq [3][4];
  logic [31:0] m_hist [3][16];
  int m_hn [3];
  logic [31:0] m_st [3], m_pv [3], m_mk [3], m_cp [3], m_rd [3];
  logic m_irq [3];
  pio_input_edge_irq_if b0 ();
  pio_input_edge_irq_if b1 ();
  pio_input_edge_irq_if b2 ();
  assign b0.address = address;
  assign b0.chipselect = chipselect;
  assign b0.write_n = write_n;
  assign b0.writedata = writedata;
  assign b1.address = address;
  assign b1.chipselect = chipselect;
  assign b1.write_n = write_n;
  assign b1.writedata = writedata;
  assign b2.address = address;
  assign b2.chipselect = chipselect;
  assign b2.write_n = write_n;
  assign b2.writedata = writedata;
  pio_input_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2))
    u0 (.clk(clk), .reset(reset), .in_port(in0), .bus(b0));
  pio_input_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0))
    u1 (.clk(clk), .reset(reset), .in_port(in1), .bus(b1));
  pio_input_edge_irq #(.WIDTH(32), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1))
    u2 (.clk(clk), .reset(reset), .in_port(in2), .bus(b2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Stable flips a bit once the last D synchronised samples all disagree with it.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] m, inv, syn, ev, agree, ns, clr;
      logic wr;
      m = 32'((64'd1 << WS[k]) - 64'd1);
      inv = k == 0 ? {24'd0, in0} : k == 1 ? {24'd0, in1} : in2;
      if (reset) begin
        for (int j = 0; j < 4; j++) m_sq[k][j] = '0;
        m_hn[k] = 0;
        m_st[k] = '0;
        m_pv[k] = '0;
        m_mk[k] = '0;
        m_cp[k] = '0;
        m_rd[k] = '0;
        m_irq[k] = 1'b0;
      end else begin
        syn = m_sq[k][SS[k]-1];
        for (int j = 3; j > 0; j--) m_sq[k][j] = m_sq[k][j-1];
        m_sq[k][0] = inv;
        if (DS[k] == 0) ns = syn;
        else begin
          for (int j = 15; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
          m_hist[k][0] = syn;
          if (m_hn[k] < 16) m_hn[k]++;
          agree = m;
          for (int j = 0; j < DS[k]; j++) agree &= m_hist[k][j] ^ m_st[k];
          ns = m_hn[k] >= DS[k] ? m_st[k] ^ agree : m_st[k];
        end
        ev = ES[k] == 0 ? m_st[k] & ~m_pv[k] : ES[k] == 1 ? ~m_st[k] & m_pv[k] : m_st[k] ^ m_pv[k];
        wr = chipselect && !write_n;
        clr = (wr && address == 2'd3) ? writedata & m : 32'd0;
        m_rd[k] = address == 2'd0 ? m_st[k] : address == 2'd2 ? m_mk[k] : address == 2'd3 ? m_cp[k] : 32'd0;
        m_irq[k] = |(m_cp[k] & m_mk[k]);
        m_cp[k] = (m_cp[k] & ~clr) | ev;
        if (wr && address == 2'd2) m_mk[k] = writedata & m;
        m_pv[k] = m_st[k];
        m_st[k] = ns;
      end
    end
  endtask
  task automatic tick(input int n = 1);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("rd0", b0.readdata, m_rd[0]);
      chk("rd1", b1.readdata, m_rd[1]);
      chk("rd2", b2.readdata, m_rd[2]);
      chk("irq0", {31'd0, b0.irq}, {31'd0, m_irq[0]});
      chk("irq1", {31'd0, b1.irq}, {31'd0, m_irq[1]});
      chk("irq2", {31'd0, b2.irq}, {31'd0, m_irq[2]});
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = d;
    tick();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    in0 = 8'hFF;
    tick(3);
    chk("reset_rd", b0.readdata, 32'd0);
    chk("reset_irq", {31'd0, b0.irq}, 32'd0);
    address = 2'd2;
    tick();
    reset = 1'b0;
    tick();
    chk("reset_mask", b0.readdata, 32'd0);
    address = 2'd0;
    tick(10);
    chk("held_high_stable", b0.readdata, 32'hFF);
    address = 2'd3;
    tick(2);
    chk("held_high_capture", b0.readdata, 32'hFF);
    in0 = 8'hFE;
    tick(12);
    wr(2'd3, 32'hFFFF_FFFF);
    in0 = 8'hFF;
    tick();
    in0 = 8'hFE;
    tick();
    in0 = 8'hFF;
    tick(12);
    chk("bounce_capture", b0.readdata, 32'h01);
    address = 2'd0;
    tick(2);
    chk("bounce_stable", b0.readdata, 32'hFF);
    wr(2'd3, 32'hFFFF_FFFF);
    in1 = 8'h05;
    tick(6);
    address = 2'd3;
    tick();
    chk("rise_capture", b1.readdata, 32'h05);
    in1 = 8'h00;
    tick(7);
    chk("fall_ignored", b1.readdata, 32'h05);
    wr(2'd2, 32'h4);
    wr(2'd3, 32'hFFFF_FFFF);
    tick();
    chk("irq_clear_idle", {31'd0, b1.irq}, 32'd0);
    in1 = 8'h05;
    tick(6);
    chk("irq_set", {31'd0, b1.irq}, 32'd1);
    wr(2'd3, 32'h4);
    tick();
    chk("irq_w1c", {31'd0, b1.irq}, 32'd0);
    chk("w1c_remaining", b1.readdata, 32'h01);
    wr(2'd2, 32'h8);
    in1 = 8'h0D;
    tick(7);
    chk("irq_bit3", {31'd0, b1.irq}, 32'd1);
    in1 = 8'h05;
    tick(6);
    in1 = 8'h0D;
    tick(3);
    wr(2'd3, 32'h8);
    tick(2);
    chk("set_wins", b1.readdata & 32'h8, 32'h8);
    chk("set_wins_irq", {31'd0, b1.irq}, 32'd1);
    in2 = 32'hFFFF_FFFF;
    tick(8);
    wr(2'd3, 32'hFFFF_FFFF);
    in2 = 32'h0;
    tick(8);
    chk("fall_capture32", b2.readdata, 32'hFFFF_FFFF);
    address = 2'd1;
    tick();
    chk("addr1_zero", b2.readdata, 32'd0);
    wr(2'd0, $urandom);
    wr(2'd1, $urandom);
    address = 2'd3;
    tick(2);
    chk("ignored_writes_cap", b2.readdata, 32'hFFFF_FFFF);
    address = 2'd2;
    tick();
    chk("ignored_writes_mask", b2.readdata, 32'h8);
    for (int c = 0; c < 3000; c++) begin
      reset = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 7) == 0) in0 = 8'($urandom);
      if ($urandom_range(0, 2) == 0) in0 ^= 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) in1 = 8'($urandom);
      if ($urandom_range(0, 5) == 0) in2 = $urandom;
      address = 2'($urandom);
      chipselect = $urandom_range(0, 3) == 0;
      write_n = $urandom_range(0, 1) == 0;
      writedata = $urandom;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
